// File: rtl/sample_frame_pkg.sv
// Shared widths and control-state encoding for the sample frame packer.
// Widths here are the defaults; the top module exposes them as parameters.
package sample_frame_pkg;

   localparam int DATAW = 16;
   localparam int SAW   = 8;
   localparam int NSAMP = 8;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

endpackage

// File: rtl/sample_bank.sv
// Eight-slot sample register bank plus its shift amount: indexed single-slot writes or a whole-frame load.
// One-cycle write latency; no handshake of its own, the packer controls every enable.
module sample_bank
   import sample_frame_pkg::*;
#(
   parameter int DW = DATAW,
   parameter int SW = SAW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            wr_en,
   input  logic [2:0]      wr_idx,
   input  logic [DW-1:0]   wr_dat,
   input  logic            sa_en,
   input  logic [SW-1:0]   sa_dat,
   input  logic            ld_en,
   input  logic [8*DW-1:0] ld_slots,
   input  logic [SW-1:0]   ld_sa,
   output logic [8*DW-1:0] slots,
   output logic [SW-1:0]   sa
);

   // A whole-frame load takes priority over slot writes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slots <= '0;
         sa    <= '0;
      end else if (ld_en) begin
         slots <= ld_slots;
         sa    <= ld_sa;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (wr_en && (wr_idx == 3'(i))) begin
               slots[i*DW +: DW] <= wr_dat;
            end
         end
         if (sa_en) begin
            sa <= sa_dat;
         end
      end
   end

endmodule

// File: rtl/sample_frame_packer.sv
// Packs 8 serial samples into frame a..h + sa; frame_valid rises the cycle after the 8th accepted sample.
// Frame is held until frame_ready; SAMPLE_FRAME_PACKER_DBUF_EN adds a fill bank so input keeps flowing while a frame is held.
module sample_frame_packer #(
   parameter int DATAW = sample_frame_pkg::DATAW,
   parameter int SAW   = sample_frame_pkg::SAW,
   parameter int NSAMP = sample_frame_pkg::NSAMP
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [DATAW-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SAW-1:0]   cfg_sa,
   output logic [DATAW-1:0] a,
   output logic [DATAW-1:0] b,
   output logic [DATAW-1:0] c,
   output logic [DATAW-1:0] d,
   output logic [DATAW-1:0] e,
   output logic [DATAW-1:0] f,
   output logic [DATAW-1:0] g,
   output logic [DATAW-1:0] h,
   output logic [SAW-1:0]   sa,
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic [3:0]       fill_cnt
);

   if (NSAMP != 8) begin : g_nsamp_chk
      $error("sample_frame_packer: NSAMP must be 8, a..h are discrete ports");
   end

   logic                 accept;
   logic                 last;
   logic [8*DATAW-1:0]   out_slots;
   logic [SAW-1:0]       out_sa;

   assign accept = in_valid & in_ready;
   assign last   = accept & (fill_cnt == 4'd7);

`ifdef SAMPLE_FRAME_PACKER_DBUF_EN
   logic                 consume;
   logic                 swap;
   logic [8*DATAW-1:0]   fill_slots;
   logic [8*DATAW-1:0]   swap_slots;
   logic [SAW-1:0]       fill_sa;

   // A full fill bank (fill_cnt = 8) is the only thing that stalls the input.
   assign in_ready = (fill_cnt != 4'd8);
   assign consume  = frame_valid & frame_ready;
   assign swap     = (last & (~frame_valid | frame_ready)) | (~in_ready & frame_ready);

   // On the completing sample, slot 7 is still in flight and is forwarded into the output bank.
   always_comb begin
      swap_slots = fill_slots;
      if (in_ready) begin
         swap_slots[7*DATAW +: DATAW] = in_data;
      end
   end

   sample_bank #(.DW(DATAW), .SW(SAW)) u_fill_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (accept),
      .wr_idx   (fill_cnt[2:0]),
      .wr_dat   (in_data),
      .sa_en    (accept & (fill_cnt == 4'd0)),
      .sa_dat   (cfg_sa),
      .ld_en    (1'b0),
      .ld_slots ('0),
      .ld_sa    ('0),
      .slots    (fill_slots),
      .sa       (fill_sa)
   );

   sample_bank #(.DW(DATAW), .SW(SAW)) u_out_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (1'b0),
      .wr_idx   (3'd0),
      .wr_dat   ('0),
      .sa_en    (1'b0),
      .sa_dat   ('0),
      .ld_en    (swap),
      .ld_slots (swap_slots),
      .ld_sa    (fill_sa),
      .slots    (out_slots),
      .sa       (out_sa)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_valid <= 1'b0;
         fill_cnt    <= 4'd0;
      end else begin
         if (swap) begin
            frame_valid <= 1'b1;
         end else if (consume) begin
            frame_valid <= 1'b0;
         end
         // Completing without a swap parks the count at 8 until the output bank drains.
         if (swap) begin
            fill_cnt <= 4'd0;
         end else if (accept) begin
            fill_cnt <= fill_cnt + 4'd1;
         end
      end
   end
`else
   sample_frame_pkg::state_t state;

   assign in_ready = (state == sample_frame_pkg::FILL);

   sample_bank #(.DW(DATAW), .SW(SAW)) u_bank (
      .clk      (clk),
      .rst      (rst),
      .wr_en    (accept),
      .wr_idx   (fill_cnt[2:0]),
      .wr_dat   (in_data),
      .sa_en    (accept & (fill_cnt == 4'd0)),
      .sa_dat   (cfg_sa),
      .ld_en    (1'b0),
      .ld_slots ('0),
      .ld_sa    ('0),
      .slots    (out_slots),
      .sa       (out_sa)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= sample_frame_pkg::FILL;
         frame_valid <= 1'b0;
         fill_cnt    <= 4'd0;
      end else begin
         case (state)
            sample_frame_pkg::FILL: begin
               if (last) begin
                  state       <= sample_frame_pkg::HOLD;
                  frame_valid <= 1'b1;
                  fill_cnt    <= 4'd0;
               end else if (accept) begin
                  fill_cnt <= fill_cnt + 4'd1;
               end
            end
            sample_frame_pkg::HOLD: begin
               if (frame_ready) begin
                  state       <= sample_frame_pkg::FILL;
                  frame_valid <= 1'b0;
               end
            end
         endcase
      end
   end
`endif

   assign a  = out_slots[0*DATAW +: DATAW];
   assign b  = out_slots[1*DATAW +: DATAW];
   assign c  = out_slots[2*DATAW +: DATAW];
   assign d  = out_slots[3*DATAW +: DATAW];
   assign e  = out_slots[4*DATAW +: DATAW];
   assign f  = out_slots[5*DATAW +: DATAW];
   assign g  = out_slots[6*DATAW +: DATAW];
   assign h  = out_slots[7*DATAW +: DATAW];
   assign sa = out_sa;

endmodule
